// File: rtl/add_seq_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package add_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_4b.sv
// 4-bit ripple adder slice: the only arithmetic datapath of add_seq_ctrl.
module adder_4b (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    logic [4:0] total;

    always_comb begin
        total = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};
        S     = total[3:0];
        Cout  = total[4];
    end

endmodule

// File: rtl/add_seq_ctrl.sv
// Sequential nibble-serial adder: one nibble per clock through a shared adder_4b.
// Optional build macro ADD_SEQ_SUB_EN adds a 'sub' input selecting A - B.
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NIBBLE_W*WORDS-1:0] op_a,
    input  logic [NIBBLE_W*WORDS-1:0] op_b,
    input  logic                    cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                    sub,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [NIBBLE_W*WORDS-1:0] sum,
    output logic                    cout
);

    localparam int W  = NIBBLE_W * WORDS;
    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t            state;
    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic              carry;
    logic [IW-1:0]     idx;

    logic              sub_sel;
    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic              c_nib;

    always_comb begin
`ifdef ADD_SEQ_SUB_EN
        sub_sel = sub;
`else
        sub_sel = 1'b0;
`endif
    end

    always_comb begin
        a_nib = a_reg[int'(idx)*NIBBLE_W +: NIBBLE_W];
        b_nib = b_reg[int'(idx)*NIBBLE_W +: NIBBLE_W];
    end

    adder_4b u_adder (
        .A    (a_nib),
        .B    (b_nib),
        .Cin  (carry),
        .S    (s_nib),
        .Cout (c_nib)
    );

    // Subtraction is folded in at capture time (invert B, force carry-in),
    // so the RUN datapath is identical for both operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= op_a;
                        b_reg <= sub_sel ? ~op_b : op_b;
                        carry <= sub_sel ? 1'b1 : cin;
                        sum   <= '0;
                        cout  <= 1'b0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[int'(idx)*NIBBLE_W +: NIBBLE_W] <= s_nib;
                    carry <= c_nib;
                    if (idx == LAST) begin
                        cout  <= c_nib;
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl (WORDS=4): directed table, random ops, corner sequences.
module tb_add_seq_ctrl;

    localparam int WORDS = 4;
    localparam int W     = 4 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int total = 0;
    int bad   = 0;

    add_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
`ifdef ADD_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic         s;
        logic [W-1:0] es;
        logic         ec;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic, result bit W is the carry-out.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
        if (s)
            return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + (W+1)'(c);
    endfunction

    // Caller is positioned just after an edge with the DUT idle.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s,
                          input logic [W-1:0] es, input logic ec);
        int lat;
        logic got;
        op_a = a; op_b = b; cin = c; sub = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        chk({tag, ".busy_run"}, 32'(busy), 32'd1);
        lat = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) got = 1'b1;
        end
        chk({tag, ".done_seen"}, 32'(got), 32'd1);
        chk({tag, ".latency"}, 32'(lat), 32'(WORDS));
        chk({tag, ".sum"}, 32'(sum), 32'(es));
        chk({tag, ".cout"}, 32'(cout), 32'(ec));
        chk({tag, ".busy_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
        chk({tag, ".sum_hold"}, 32'(sum), 32'(es));
        chk({tag, ".cout_hold"}, 32'(cout), 32'(ec));
    endtask

    initial begin
        logic [W:0] r;
        logic [W-1:0] ra, rb;
        logic rc, rs;
        int npulse;
        logic [W-1:0] psum;
        logic pcout;

        vecs.push_back('{"zero",    16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{"ripple",  16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0});
        vecs.push_back('{"wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{"max",     16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
        vecs.push_back('{"cin_only",16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0});
`ifdef ADD_SEQ_SUB_EN
        vecs.push_back('{"sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
        vecs.push_back('{"sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1});
`endif

        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.sum",  32'(sum),  32'd0);
        chk("reset.cout", 32'(cout), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_hold.busy", 32'(busy), 32'd0);

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].es, vecs[i].ec);

        for (int n = 0; n < 12; n++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
`ifdef ADD_SEQ_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            r = model(ra, rb, rc, rs);
            run_op($sformatf("rand%0d", n), ra, rb, rc, rs, r[W-1:0], r[W]);
        end

        // Start during RUN must be ignored: first result, single done pulse.
        op_a = 16'h1234; op_b = 16'h0FFF; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        op_a = 16'hFFFF; op_b = 16'hFFFF; cin = 1'b1; start = 1'b1;
        npulse = 0; psum = '0; pcout = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 1) start = 1'b0;
            if (done) begin
                npulse++;
                psum = sum;
                pcout = cout;
            end
        end
        chk("busy_start.pulses", 32'(npulse), 32'd1);
        chk("busy_start.sum",    32'(psum),   32'h2233);
        chk("busy_start.cout",   32'(pcout),  32'd0);

        // Reset while idx=2 aborts with no done pulse.
        op_a = 16'hFFFF; op_b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.sum",  32'(sum),  32'd0);
        chk("abort.cout", 32'(cout), 32'd0);
        npulse = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) npulse++;
        end
        chk("abort.quiet", 32'(npulse), 32'd0);
        run_op("after_abort", 16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1, "timeout");
    end

endmodule
